// File: rtl/bcd2bin_conv_pkg.sv
// bcd2bin_conv_pkg: shared definitions for the BCD-to-binary converter.
//   - state_e        : FSM state encoding (2 bits)
//   - BCD_* consts   : digit adjust threshold/value and largest legal digit
package bcd2bin_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_CONV  = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd2bin_dig_adj.sv
// bcd2bin_dig_adj: combinational single-digit step of reverse double-dabble.
//   dig_i     [3:0] : BCD digit after the right shift
//   dig_o     [3:0] : dig_i - 3 when dig_i >= 8, else dig_i
//   invalid_o       : dig_i is not a legal BCD digit (> 9)
module bcd2bin_dig_adj
  import bcd2bin_conv_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o,
  output logic       invalid_o
);

  // A shifted-in half-ten lands as 8 in the lower digit; removing 3 turns
  // it into the correct value 5. Inputs here are always >= 8 when adjusted,
  // so the 4-bit subtraction cannot wrap.
  assign dig_o     = (dig_i >= BCD_ADJ_THRESH) ? (dig_i - BCD_ADJ_VAL) : dig_i;
  assign invalid_o = (dig_i > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd2bin_conv.sv
// bcd2bin_conv: multi-cycle BCD-to-binary converter (reverse double-dabble).
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : conversion request, sampled only in IDLE
//   bcd_in       : packed BCD operand, digit 0 in bits [3:0]
//   busy         : conversion in progress (start edge through done cycle)
//   done         : one-cycle pulse, bin_out/err valid
//   bin_out      : converted value, held until the next result
//   err          : set with done when any input digit > 9
//   dbg_state_o  : current FSM state for observation
//
// Handshake: start is a level sampled on a rising edge while in IDLE; that
// edge captures bcd_in and raises busy. busy stays high until and including
// the single cycle done is high. start seen outside IDLE is dropped, not
// queued; a start held high re-launches on the first IDLE edge after done.
module bcd2bin_conv
  import bcd2bin_conv_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW   = 14,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err,
  output state_e            dbg_state_o
);

  localparam int DW = 4 * NDIG;
  localparam int SW = DW + BW;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [BW-1:0]    bin_q, bin_d;
  logic             err_q, err_d;

  logic [SW-1:0]    sr_shift;
  logic [DW-1:0]    adj_in;
  logic [DW-1:0]    adj_out;
  logic [NDIG-1:0]  dig_bad;

  assign sr_shift = sr_q >> 1;

  // The digit cells do double duty: in CHECK they look at the captured
  // operand to flag illegal digits, in CONV they adjust the shifted digits.
  assign adj_in = (state_q == ST_CHECK) ? sr_q[SW-1:BW] : sr_shift[SW-1:BW];

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd2bin_dig_adj u_adj (
      .dig_i     (adj_in[4*g +: 4]),
      .dig_o     (adj_out[4*g +: 4]),
      .invalid_o (dig_bad[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {bcd_in, {BW{1'b0}}};
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (|dig_bad) begin
          err_d   = 1'b1;
          bin_d   = '0;
          state_d = ST_FIN;
        end else begin
          err_d   = 1'b0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_d  = {adj_out, sr_shift[BW-1:0]};
        cnt_d = cnt_q + CW'(1);
        // Binary bits never reach the digit field, so the low part of the
        // shifted value on the last step is the finished result.
        if (cnt_q == CW'(BW - 1)) begin
          bin_d   = sr_shift[BW-1:0];
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign bin_out     = bin_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
